lane_deserializer: RTL
======================

Name: lane_deserializer

Overview:
- Receive-side counterpart of the lane serializer. It consumes N2 serial lanes that each carry one N1-bit word, MSB first.
- Reassembles the words into a frame and presents them one per handshake in lane order: lane 0 first, lane N2-1 last.
- Two stages: a collect shift register and a hold buffer. The next frame can shift in while the previous frame drains.
- InReady feeds the upstream serializer's keep/stall control as its inverse.

Parameters:
- N1, 76, word width and number of serial bits per lane per frame.
- N2, 7, number of lanes, which is also the number of words per frame.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  one serial bit is present on every lane this cycle.
- InReady  output  1  the block accepts a bit column this cycle.
- In  input  N2  serial bits; In[x] is lane x.
- OutValid  output  1  Out holds a valid word.
- OutReady  input  1  downstream accepts Out.
- Out  output  N1  current word.
- OutLast  output  1  the current word is the last word (lane N2-1) of its frame.

Behaviour:
- Reset (sampled on the rising edge while Reset=1):
  - Collect register, hold buffer, bit count and word index all cleared to 0.
  - Collector state = COLLECT; hold state = EMPTY.
  - OutValid=0, OutLast=0, Out=0.
  - InReady is forced to 0 while Reset=1.
  - Any partial frame or undrained frame is discarded, with no output.
- Collector FSM, states COLLECT and FULL:
  - InReady = (state==COLLECT) && !Reset.
  - On an accept (InValid && InReady), every lane x shifts left by one with In[x] entering the LSB, and bitcnt increments.
  - The first bit received on a lane ends up at bit N1-1.
  - Accept with bitcnt==N1-1 completes the frame:
    - If the hold buffer can load this cycle (see the hold rules), the completed lanes, including this bit, are written straight into hold. bitcnt returns to 0 and the state stays COLLECT.
    - Otherwise the state goes to FULL, with bitcnt held at N1-1 and the lanes frozen.
  - In FULL with the hold buffer able to load: transfer the lanes into hold, set bitcnt to 0, and go to COLLECT. InReady returns to 1 on the next cycle.
  - InValid=0 in COLLECT means no shift and no count change. Gaps of any length are legal.
- Hold buffer FSM, states EMPTY and DRAIN, with index idx of width $clog2(N2):
  - Out = hold[idx]. OutValid = (state==DRAIN). OutLast = OutValid && idx==N2-1.
  - A handshake is OutValid && OutReady. It increments idx.
  - A handshake with idx==N2-1 finishes the frame.
  - The hold buffer can load when it is EMPTY, or when it is finishing its frame in this same cycle. The second case gives no bubble between frames.
  - On a load: idx=0, state=DRAIN.
  - On finishing without a load: state=EMPTY. Out retains its last value and idx returns to 0.
  - When OutValid=1 and OutReady=0, Out and OutLast are held stable.
- Latency:
  - Final bit accepted on edge k, with hold loadable: OutValid=1 with word 0 is visible after edge k.
  - Minimum frame period is max(N1, N2) cycles.
- Simultaneous events:
  - Collector completion or FULL transfer in the same cycle as the last-word handshake: hold reloads, and OutValid stays 1 continuously.
  - A completion while hold is mid-drain goes to FULL. There is no overflow and no data loss.
- Widths: bitcnt is $clog2(N1) bits. No arithmetic is done on the data.

Decomposition:
- Shared package lane_deser_pkg holds:
  - typedef enum collect_state_t {COLLECT, FULL}.
  - typedef enum hold_state_t {EMPTY, DRAIN}.
  - Default N1/N2 constants, shared with the serializer.
- One natural sub-module, deser_lane: a single N1-bit shift-in lane with enable and parallel read. It is instantiated N2 times by a generate loop.
- The FSMs, counters and hold buffer stay in the top module.

Test Plan:
- Basic frame (N1=8, N2=3): lanes serially carry A5, 3C, F0 with InValid held at 1 and OutReady held at 1.
  - Required: 8 accepts, then Out = A5, 3C, F0 on three consecutive cycles.
  - OutLast=1 only with F0.
- Loopback with the serializer (defaults):
  - Stimulus: load 7 random 76-bit words, shift 76 cycles, and drive the serializer's keep input from !InReady.
  - Required: words come out in load order, bit-exact, with OutLast on word 7.
- Backpressure (N1=8, N2=3): OutReady=0 while a second frame completes.
  - Required: the collector goes to FULL and InReady=0.
  - Required: Out holds A5 stable.
  - Required: after OutReady=1, three handshakes, then the second frame's word 0 on the very next cycle with no bubble.
- Gapped input: InValid toggles 1,0,1,0 across the frame.
  - Required: same output as the basic frame; bitcnt advances only on accepts.
- Back-to-back frames with OutReady=1, N1=3, N2=3:
  - Required: frame 2 completes on the same cycle as frame 1's last-word handshake.
  - Required: OutValid stays 1 for 6 cycles, and InReady never drops.
- Mid-operation reset: assert Reset after 5 of 8 bits, and once more mid-drain.
  - Required: the next cycle shows OutValid=0 and Out=0.
  - Required: InReady=1 after reset is released.
  - Required: a fresh frame decodes correctly, with no residue from the aborted frame.

Source files
------------

// File: rtl/lane_deser_pkg.sv
// Shared types and default geometry for the lane serializer/deserializer pair.
// N1 is the word width (bits per lane per frame), N2 the lane count (words per frame).
package lane_deser_pkg;

    localparam int DEF_N1 = 76;
    localparam int DEF_N2 = 7;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } collect_state_t;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } hold_state_t;

endpackage

// File: rtl/deser_lane.sv
// One serial lane: shifts a bit into the LSB on each enable.
// The first bit received therefore ends up at bit N1-1.
module deser_lane #(
    parameter int N1 = 76
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          en,
    input  logic          din,
    output logic [N1-1:0] q
);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            q <= '0;
        end else if (en) begin
            q <= {q[N1-2:0], din};
        end
    end

endmodule

// File: rtl/lane_deserializer.sv
// Collects N2 serial lanes into a frame, then drains the frame one word per
// handshake from a hold buffer while the next frame shifts in.
module lane_deserializer
    import lane_deser_pkg::*;
#(
    parameter int N1 = DEF_N1,
    parameter int N2 = DEF_N2
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          InValid,
    output logic          InReady,
    input  logic [N2-1:0] In,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [N1-1:0] Out,
    output logic          OutLast,
    output logic          dbg_collect_state,
    output logic          dbg_hold_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and InReady depends only on collector state and Reset.
    localparam int BW = (N1 > 1) ? $clog2(N1) : 1;
    localparam int IW = (N2 > 1) ? $clog2(N2) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(N1 - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N2 - 1);

    collect_state_t cs, cs_next;
    hold_state_t    hold_st, hold_next;

    logic [BW-1:0] bitcnt;
    logic [IW-1:0] idx;
    logic [N1-1:0] lane_q    [N2];
    logic [N1-1:0] lane_next [N2];
    logic [N1-1:0] hold_q    [N2];
    logic [N1-1:0] out_q;

    logic accept;
    logic frame_done;
    logic handshake;
    logic drain_done;
    logic hold_can_load;
    logic load;

    assign accept        = InValid && InReady;
    assign frame_done    = accept && (bitcnt == LAST_BIT);
    assign handshake     = OutValid && OutReady;
    assign drain_done    = handshake && (idx == LAST_IDX);
    assign hold_can_load = (hold_st == EMPTY) || drain_done;
    assign load          = (frame_done || (cs == FULL)) && hold_can_load;

    // On a completing accept the final bit is folded in so hold loads the whole frame now.
    for (genvar x = 0; x < N2; x++) begin : g_lane
        deser_lane #(.N1(N1)) u_lane (
            .Clock (Clock),
            .Reset (Reset),
            .en    (accept),
            .din   (In[x]),
            .q     (lane_q[x])
        );
        assign lane_next[x] = frame_done ? {lane_q[x][N1-2:0], In[x]} : lane_q[x];
    end

    // Collector FSM
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cs <= COLLECT;
        end else begin
            cs <= cs_next;
        end
    end

    always_comb begin
        cs_next = cs;
        case (cs)
            COLLECT: if (frame_done && !hold_can_load) cs_next = FULL;
            FULL:    if (hold_can_load) cs_next = COLLECT;
            default: cs_next = COLLECT;
        endcase
    end

    always_comb begin
        InReady = (cs == COLLECT) && !Reset;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            bitcnt <= '0;
        end else if (load) begin
            bitcnt <= '0;
        end else if (accept && !frame_done) begin
            bitcnt <= bitcnt + BW'(1);
        end
    end

    // Hold buffer FSM
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hold_st <= EMPTY;
        end else begin
            hold_st <= hold_next;
        end
    end

    always_comb begin
        hold_next = hold_st;
        case (hold_st)
            EMPTY:   if (load) hold_next = DRAIN;
            DRAIN:   if (drain_done && !load) hold_next = EMPTY;
            default: hold_next = EMPTY;
        endcase
    end

    always_comb begin
        OutValid = (hold_st == DRAIN);
        OutLast  = OutValid && (idx == LAST_IDX);
        Out      = out_q;
    end

    // Out is registered as hold[idx] so it keeps the last word after a drain empties hold.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            idx   <= '0;
            out_q <= '0;
            for (int x = 0; x < N2; x++) begin
                hold_q[x] <= '0;
            end
        end else if (load) begin
            for (int x = 0; x < N2; x++) begin
                hold_q[x] <= lane_next[x];
            end
            out_q <= lane_next[0];
            idx   <= '0;
        end else if (drain_done) begin
            idx <= '0;
        end else if (handshake) begin
            idx   <= idx + IW'(1);
            out_q <= hold_q[idx + IW'(1)];
        end
    end

    assign dbg_collect_state = cs;
    assign dbg_hold_state    = hold_st;

endmodule
